// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding and the data width used by
// every byte-stream port in the UART slice.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [0:0] {
        ARB_IDLE,
        ARB_LOCK
    } uart_arb_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin pick: first set request bit searching upward from
// last_ptr_i+1, wrapping modulo NUM_REQ.
module uart_rr_pick #(
    parameter int NUM_REQ = 4,
    localparam int PTR_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   last_ptr_i,
    output logic [PTR_W-1:0]   idx_o,
    output logic               any_o
);

    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base,
                                                  input int              offs);
        int sum;
        sum = (int'(base) + offs) % NUM_REQ;
        return PTR_W'(sum);
    endfunction

    // Offset 1 is checked first, so the previous owner gets the lowest priority.
    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!any_o && req_i[wrap_idx(last_ptr_i, i)]) begin
                idx_o = wrap_idx(last_ptr_i, i);
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ byte-stream requesters,
// granting per message with a burst limit. Optional stall timeout: UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int BURST_LEN   = 16,
    parameter int TIMEOUT_CYC = 1024,
    localparam int GRANT_W    = $clog2(NUM_REQ)
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic [NUM_REQ*UART_DATA_W-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]             req_data_vld_i,
    input  logic [NUM_REQ-1:0]             req_last_i,
    output logic [NUM_REQ-1:0]             req_data_rdy_o,
    output logic [UART_DATA_W-1:0]         uart_tx_data_o,
    output logic                           uart_tx_data_vld_o,
    input  logic                           uart_tx_data_rdy_i,
    output logic [GRANT_W-1:0]             grant_o,
    output logic                           busy_o
);

    localparam logic [7:0]         BURST_MAX = 8'(BURST_LEN - 1);
    localparam logic [GRANT_W-1:0] PTR_INIT  = GRANT_W'(NUM_REQ - 1);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("uart_tx_arb: NUM_REQ must be 2..8");
    end
    if (BURST_LEN < 1 || BURST_LEN > 256) begin : g_bad_burst_len
        $error("uart_tx_arb: BURST_LEN must be 1..256");
    end
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
        $error("uart_tx_arb: TIMEOUT_CYC must be 1..65535");
    end

    uart_arb_state_t     state_q, state_d;
    logic [GRANT_W-1:0]  grant_q, grant_d;
    logic [GRANT_W-1:0]  last_ptr_q, last_ptr_d;
    logic [7:0]          byte_cnt_q, byte_cnt_d;

    logic [GRANT_W-1:0]     pick_idx;
    logic                   pick_any;
    logic [UART_DATA_W-1:0] req_bytes [NUM_REQ];
    logic [UART_DATA_W-1:0] gnt_data;
    logic                   gnt_vld;
    logic                   gnt_last;
    logic                   xfer;

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYC);
    logic [15:0] idle_cnt_q, idle_cnt_d;
`endif

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req_i      (req_data_vld_i),
        .last_ptr_i (last_ptr_q),
        .idx_o      (pick_idx),
        .any_o      (pick_any)
    );

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_bytes[i] = req_data_i[i*UART_DATA_W +: UART_DATA_W];
        end
    end

    assign gnt_data = req_bytes[grant_q];
    assign gnt_vld  = req_data_vld_i[grant_q];
    assign gnt_last = req_last_i[grant_q];
    assign xfer     = (state_q == ARB_LOCK) && gnt_vld && uart_tx_data_rdy_i;

    // Pure pass-through while locked; nothing reaches uart_tx from IDLE.
    always_comb begin
        uart_tx_data_o     = '0;
        uart_tx_data_vld_o = 1'b0;
        req_data_rdy_o     = '0;
        if (state_q == ARB_LOCK) begin
            uart_tx_data_o          = gnt_data;
            uart_tx_data_vld_o      = gnt_vld;
            req_data_rdy_o[grant_q] = uart_tx_data_rdy_i;
        end
    end

    assign grant_o = grant_q;
    assign busy_o  = (state_q == ARB_LOCK);

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_ptr_d = last_ptr_q;
        byte_cnt_d = byte_cnt_q;
`ifdef UART_TX_ARB_TIMEOUT_EN
        idle_cnt_d = '0;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    grant_d    = pick_idx;
                    byte_cnt_d = '0;
                    state_d    = ARB_LOCK;
                end
            end
            ARB_LOCK: begin
                // A last byte landing on the burst limit still releases only once.
                if (xfer) begin
                    byte_cnt_d = byte_cnt_q + 8'd1;
                    if (gnt_last || (byte_cnt_q == BURST_MAX)) begin
                        state_d    = ARB_IDLE;
                        last_ptr_d = grant_q;
                    end
                end
`ifdef UART_TX_ARB_TIMEOUT_EN
                if (!gnt_vld) begin
                    idle_cnt_d = idle_cnt_q + 16'd1;
                    if (idle_cnt_d == TIMEOUT_LIM) begin
                        state_d    = ARB_IDLE;
                        last_ptr_d = grant_q;
                        idle_cnt_d = '0;
                    end
                end
`endif
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ARB_IDLE;
            grant_q    <= '0;
            last_ptr_q <= PTR_INIT;
            byte_cnt_q <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            idle_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_ptr_q <= last_ptr_d;
            byte_cnt_q <= byte_cnt_d;
`ifdef UART_TX_ARB_TIMEOUT_EN
            idle_cnt_q <= idle_cnt_d;
`endif
        end
    end

    a_rdy_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_n_i)
        $onehot0(req_data_rdy_o));
    a_idle_quiet : assert property (@(posedge clk_i) disable iff (!rst_n_i)
        (state_q == ARB_IDLE) |-> (!uart_tx_data_vld_o && (req_data_rdy_o == '0)));
    a_burst_bound : assert property (@(posedge clk_i) disable iff (!rst_n_i)
        (state_q == ARB_LOCK) |-> (int'(byte_cnt_q) < BURST_LEN));

endmodule
